// File: rtl/dcache_ctrl.sv
// Sequencing controller for a 2-way set-associative data cache: same-cycle hits,
// dirty-victim write-back, line refill with replay, and a wrapping miss counter.
module dcache_ctrl #(
  parameter int MEM_W = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             cpu_write_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_data_i,
  output logic [31:0]      cpu_data_o,
  output logic             cpu_stall_o,
  output logic             sram_enable_o,
  output logic             sram_write_o,
  output logic [3:0]       sram_addr_o,
  output logic [24:0]      sram_tag_o,
  output logic [MEM_W-1:0] sram_data_o,
  input  logic             sram_hit_i,
  input  logic [24:0]      sram_tag_i,
  input  logic [MEM_W-1:0] sram_data_i,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_addr_o,
  output logic [MEM_W-1:0] mem_data_o,
  input  logic [MEM_W-1:0] mem_data_i,
  input  logic             mem_ack_i,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [2:0] {IDLE, MISS, WBACK, FETCH, REFILL} state_t;

  state_t           state, state_nxt;
  logic [31:2]      addr_q;
  logic [31:0]      data_q;
  logic             write_q;
  logic             capture;
  logic [CNT_W-1:0] miss_cnt;
  logic             mem_en_q, mem_en_nxt;
  logic             mem_wr_q, mem_wr_nxt;
  logic [31:0]      mem_addr_q, mem_addr_nxt;
  logic [MEM_W-1:0] mem_data_q, mem_data_nxt;
  logic [31:0]      fetch_addr;
  logic [22:0]      cur_tag;
  logic             unused_byte_offset;

  function automatic logic [MEM_W-1:0] merge_word(input logic [MEM_W-1:0] line,
                                                  input logic [2:0]       word,
                                                  input logic [31:0]      data);
    logic [MEM_W-1:0] merged;
    merged = line;
    merged[{word, 5'b0} +: 32] = data;
    return merged;
  endfunction

  // Accesses are word-granular; the byte offset never affects the line.
  assign unused_byte_offset = ^cpu_addr_i[1:0];

  assign sram_addr_o  = (state == IDLE) ? cpu_addr_i[8:5]  : addr_q[8:5];
  assign cur_tag      = (state == IDLE) ? cpu_addr_i[31:9] : addr_q[31:9];
  assign fetch_addr   = {addr_q[31:5], 5'b0};
  assign cpu_data_o   = sram_data_i[{cpu_addr_i[4:2], 5'b0} +: 32];
  assign cpu_stall_o  = cpu_req_i & ~((state == IDLE) & sram_hit_i);

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign miss_cnt_o   = miss_cnt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    capture       = 1'b0;
    mem_en_nxt    = mem_en_q;
    mem_wr_nxt    = mem_wr_q;
    mem_addr_nxt  = mem_addr_q;
    mem_data_nxt  = mem_data_q;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = {2'b00, cur_tag};
    sram_data_o   = sram_data_i;

    unique case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            sram_enable_o = 1'b1;
            if (cpu_write_i) begin
              sram_write_o = 1'b1;
              sram_tag_o   = {2'b11, cpu_addr_i[31:9]};
              sram_data_o  = merge_word(sram_data_i, cpu_addr_i[4:2], cpu_data_i);
            end
          end else begin
            capture   = 1'b1;
            state_nxt = MISS;
          end
        end
      end
      MISS: begin
        mem_en_nxt = 1'b1;
        // The SRAM presents the LRU victim here; a valid dirty victim goes out first.
        if (sram_tag_i[24] & sram_tag_i[23]) begin
          mem_wr_nxt   = 1'b1;
          mem_addr_nxt = {sram_tag_i[22:0], addr_q[8:5], 5'b0};
          mem_data_nxt = sram_data_i;
          state_nxt    = WBACK;
        end else begin
          mem_wr_nxt   = 1'b0;
          mem_addr_nxt = fetch_addr;
          state_nxt    = FETCH;
        end
      end
      WBACK: begin
        if (mem_ack_i) begin
          mem_wr_nxt   = 1'b0;
          mem_addr_nxt = fetch_addr;
          state_nxt    = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          mem_en_nxt    = 1'b0;
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {1'b1, write_q, addr_q[31:9]};
          sram_data_o   = write_q ? merge_word(mem_data_i, addr_q[4:2], data_q) : mem_data_i;
          state_nxt     = REFILL;
        end
      end
      REFILL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      miss_cnt   <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      mem_en_q   <= mem_en_nxt;
      mem_wr_q   <= mem_wr_nxt;
      mem_addr_q <= mem_addr_nxt;
      mem_data_q <= mem_data_nxt;
      if (capture) begin
        addr_q   <= cpu_addr_i[31:2];
        data_q   <= cpu_data_i;
        write_q  <= cpu_write_i;
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural 2-way SRAM model, hand-timed memory
// acks, and a narrow-counter instance for the miss-counter wrap.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         sram_en, sram_wr;
  logic [3:0]   sram_idx;
  logic [24:0]  sram_tag_out, sram_tag_in;
  logic [255:0] sram_line_out, sram_line_in;
  logic         sram_hit;
  logic         mem_en, mem_wr, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic [15:0]  miss_cnt;

  logic         w_req, w_mem_en;
  logic [2:0]   w_cnt;
  logic [31:0]  w_unused_data, w_unused_maddr;
  logic         w_unused_stall, w_unused_sen, w_unused_swr, w_unused_mwr;
  logic [3:0]   w_unused_sidx;
  logic [24:0]  w_unused_stag;
  logic [255:0] w_unused_sline, w_unused_mline;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .sram_enable_o(sram_en), .sram_write_o(sram_wr), .sram_addr_o(sram_idx),
    .sram_tag_o(sram_tag_out), .sram_data_o(sram_line_out),
    .sram_hit_i(sram_hit), .sram_tag_i(sram_tag_in), .sram_data_i(sram_line_in),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .miss_cnt_o(miss_cnt)
  );

  // Always-missing, clean-victim instance with a 3-bit counter that acks immediately.
  dcache_ctrl #(.MEM_W(256), .CNT_W(3)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(w_req), .cpu_write_i(1'b0), .cpu_addr_i(32'h0),
    .cpu_data_i(32'h0), .cpu_data_o(w_unused_data), .cpu_stall_o(w_unused_stall),
    .sram_enable_o(w_unused_sen), .sram_write_o(w_unused_swr), .sram_addr_o(w_unused_sidx),
    .sram_tag_o(w_unused_stag), .sram_data_o(w_unused_sline),
    .sram_hit_i(1'b0), .sram_tag_i(25'h0), .sram_data_i(256'h0),
    .mem_enable_o(w_mem_en), .mem_write_o(w_unused_mwr), .mem_addr_o(w_unused_maddr),
    .mem_data_o(w_unused_mline), .mem_data_i(256'h0), .mem_ack_i(w_mem_en),
    .miss_cnt_o(w_cnt)
  );

  // SRAM model: entries indexed {way, set}; tag compare against the CPU tag, which is
  // held stable while stalled.
  logic [24:0]  tag_mem  [32] = '{default: '0};
  logic [255:0] line_mem [32] = '{default: '0};
  logic         lru      [16] = '{default: 1'b0};
  int           sram_writes = 0;
  logic         h0, h1, way;

  always_comb begin
    h0 = tag_mem[{1'b0, sram_idx}][24] && (tag_mem[{1'b0, sram_idx}][22:0] == cpu_addr[31:9]);
    h1 = tag_mem[{1'b1, sram_idx}][24] && (tag_mem[{1'b1, sram_idx}][22:0] == cpu_addr[31:9]);
    sram_hit = h0 | h1;
    way = h0 ? 1'b0 : (h1 ? 1'b1 : lru[sram_idx]);
    sram_tag_in  = tag_mem[{way, sram_idx}];
    sram_line_in = line_mem[{way, sram_idx}];
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wr) begin
        tag_mem[{way, sram_idx}]  <= sram_tag_out;
        line_mem[{way, sram_idx}] <= sram_line_out;
        sram_writes <= sram_writes + 1;
      end
      lru[sram_idx] <= ~way;
    end
  end

  typedef struct {
    int           stalls;
    int           writes;
    logic [24:0]  wtag;
    logic [255:0] wline;
    logic [31:0]  rdata;
    logic         rel_en, rel_wr;
    logic         a_write;
    logic [31:0]  a_addr;
    logic [255:0] a_data;
    logic [31:0]  b_addr;
    logic         ack_en;
    logic         done;
  } res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] w0);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    l[31:0] = w0;
    return l;
  endfunction

  // One CPU access held until released; acks pulse at request-relative cycles ack_a / ack_b.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int ack_a, input int ack_b, input logic [255:0] line,
                        output res_t r);
    r.stalls = 0; r.writes = 0; r.wtag = '0; r.wline = '0; r.rdata = '0;
    r.rel_en = 1'b0; r.rel_wr = 1'b0; r.a_write = 1'b0; r.a_addr = '0; r.a_data = '0;
    r.b_addr = '0; r.ack_en = 1'b1; r.done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
      mem_ack = (k == ack_a) || (k == ack_b);
      mem_rdata = line;
      #1;
      if (mem_ack && !mem_en) r.ack_en = 1'b0;
      if (k == ack_a) begin r.a_write = mem_wr; r.a_addr = mem_addr; r.a_data = mem_wdata; end
      if (k == ack_b) r.b_addr = mem_addr;
      if (sram_en && sram_wr) begin
        r.writes = r.writes + 1; r.wtag = sram_tag_out; r.wline = sram_line_out;
      end
      if (!cpu_stall) begin
        r.done = 1'b1; r.rdata = cpu_rdata; r.rel_en = sram_en; r.rel_wr = sram_wr;
        break;
      end
      r.stalls = r.stalls + 1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_req = 1'b0; cpu_write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t         r;
    logic [255:0] line_a, line_a_mod, line_b, line_c;
    int           wr_before;

    line_a     = make_line(32'hA000_0000, 32'hDEAD_BEEF);
    line_a_mod = line_a;
    line_a_mod[63:32] = 32'h1234_5678;
    line_b     = make_line(32'hB000_0000, 32'hB000_0000);
    line_c     = make_line(32'hC000_0000, 32'hC000_0000);

    rst = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = '0; w_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_wr", 32'(sram_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check_line("rst_mem_data", mem_wdata, 256'h0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_stall_idle", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040;
    #1;
    check("rst_stall_miss", 32'(cpu_stall), 32'd1);
    check("idle_sram_addr", 32'(sram_idx), 32'd2);
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b1;

    // Cold load: ack 10 cycles after the request.
    access(32'h0000_0040, 1'b0, 32'h0, 10, -1, line_a, r);
    check("cold_done", 32'(r.done), 32'd1);
    check("cold_stalls", 32'(r.stalls), 32'd12);
    check("cold_writes", 32'(r.writes), 32'd1);
    check("cold_wtag", 32'(r.wtag), 32'h0100_0000);
    check_line("cold_wline", r.wline, line_a);
    check("cold_fetch_wr", 32'(r.a_write), 32'd0);
    check("cold_fetch_addr", r.a_addr, 32'h0000_0040);
    check("cold_ack_en", 32'(r.ack_en), 32'd1);
    check("cold_rdata", r.rdata, 32'hDEAD_BEEF);
    check("cold_miss_cnt", 32'(miss_cnt), 32'd1);
    idle_cycle();

    // Reload hit.
    access(32'h0000_0040, 1'b0, 32'h0, -1, -1, line_a, r);
    check("hit_stalls", 32'(r.stalls), 32'd0);
    check("hit_sram_en", 32'(r.rel_en), 32'd1);
    check("hit_sram_wr", 32'(r.rel_wr), 32'd0);
    check("hit_rdata", r.rdata, 32'hDEAD_BEEF);
    idle_cycle();

    // Store hit to word 1.
    access(32'h0000_0044, 1'b1, 32'h1234_5678, -1, -1, line_a, r);
    check("st_stalls", 32'(r.stalls), 32'd0);
    check("st_writes", 32'(r.writes), 32'd1);
    check("st_wtag", 32'(r.wtag), 32'h0180_0000);
    check_line("st_wline", r.wline, line_a_mod);
    idle_cycle();

    // Second way of set 2 (clean victim).
    access(32'h0000_0240, 1'b0, 32'h0, 4, -1, line_b, r);
    check("w1_stalls", 32'(r.stalls), 32'd6);
    check("w1_fetch_addr", r.a_addr, 32'h0000_0240);
    check("w1_rdata", r.rdata, 32'hB000_0000);
    check("w1_miss_cnt", 32'(miss_cnt), 32'd2);
    idle_cycle();

    // Third tag in set 2 evicts the dirty way.
    access(32'h0000_0440, 1'b0, 32'h0, 4, 7, line_c, r);
    check("wb_stalls", 32'(r.stalls), 32'd9);
    check("wb_write", 32'(r.a_write), 32'd1);
    check("wb_addr", r.a_addr, 32'h0000_0040);
    check_line("wb_data", r.a_data, line_a_mod);
    check("wb_fetch_addr", r.b_addr, 32'h0000_0440);
    check("wb_ack_en", 32'(r.ack_en), 32'd1);
    check("wb_wtag", 32'(r.wtag), 32'h0100_0002);
    check("wb_rdata", r.rdata, 32'hC000_0000);
    check("wb_miss_cnt", 32'(miss_cnt), 32'd3);
    idle_cycle();

    // Make way 1 dirty and way 0 MRU, then reset during the write-back.
    access(32'h0000_0244, 1'b1, 32'h55AA_55AA, -1, -1, line_b, r);
    check("st2_stalls", 32'(r.stalls), 32'd0);
    idle_cycle();
    access(32'h0000_0440, 1'b0, 32'h0, -1, -1, line_c, r);
    check("hit2_stalls", 32'(r.stalls), 32'd0);
    idle_cycle();

    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0640; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rw_mem_en", 32'(mem_en), 32'd1);
    check("rw_mem_wr", 32'(mem_wr), 32'd1);
    check("rw_mem_addr", mem_addr, 32'h0000_0240);
    wr_before = sram_writes;
    #1 rst = 1'b0;
    #1;
    check("rw_async_en", 32'(mem_en), 32'd0);
    check("rw_async_addr", mem_addr, 32'h0);
    check("rw_async_cnt", 32'(miss_cnt), 32'd0);
    check("rw_async_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("stray_sram_en", 32'(sram_en), 32'd0);
    check("stray_sram_wr", 32'(sram_wr), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_writes", 32'(sram_writes - wr_before), 32'd0);
    check("stray_mem_en", 32'(mem_en), 32'd0);
    access(32'h0000_0440, 1'b0, 32'h0, -1, -1, line_c, r);
    check("post_rst_stalls", 32'(r.stalls), 32'd0);
    check("post_rst_rdata", r.rdata, 32'hC000_0000);
    idle_cycle();

    // Miss-counter wrap on the 3-bit instance: 8 back-to-back 4-cycle misses.
    check("wrap_start", 32'(w_cnt), 32'd0);
    @(negedge clk);
    w_req = 1'b1;
    repeat (28) @(negedge clk);
    #1;
    check("wrap_seven", 32'(w_cnt), 32'd7);
    @(negedge clk);
    #1;
    check("wrap_zero", 32'(w_cnt), 32'd0);
    w_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
